// File: rtl/control_pkg.sv
// Shared types and constants for the multicycle RV32I main control FSM:
// state encoding, opcodes, ALUOp classes and datapath mux selects.
package control_pkg;

  typedef enum logic [3:0] {
    RST, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_LS, EXEC_B, EXEC_U,
    MEM_LW, MEM_SW, WB_ALU, WB_MEM, ERROR
  } estado_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALUOP_R      = 4'b0110;
  localparam logic [3:0] ALUOP_I      = 4'b0010;
  localparam logic [3:0] ALUOP_LOAD   = 4'b0000;
  localparam logic [3:0] ALUOP_STORE  = 4'b0100;
  localparam logic [3:0] ALUOP_BRANCH = 4'b1100;
  localparam logic [3:0] ALUOP_LUI    = 4'b0111;
  localparam logic [3:0] ALUOP_AUIPC  = 4'b0011;

  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_RS1  = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_FOUR = 2'b01;
  localparam logic [1:0] SRC_B_IMM  = 2'b10;

  localparam logic PC_SRC_ALU    = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;
  localparam logic IORD_PC       = 1'b0;
  localparam logic IORD_ALUOUT   = 1'b1;
  localparam logic RES_ALUOUT    = 1'b0;
  localparam logic RES_MEM       = 1'b1;

  // States that own the memory port and may wait on mem_ready.
  function automatic logic is_mem_state(input estado_t s);
    return (s == FETCH) || (s == MEM_LW) || (s == MEM_SW);
  endfunction

endpackage

// File: rtl/contador_espera.sv
// Memory wait-state timeout counter: counts consecutive stalled cycles and
// flags the stall that would exceed STALL_MAX.
module contador_espera #(
  parameter int STALL_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  localparam int W = $clog2(STALL_MAX + 1);

  logic [W-1:0] count_q, count_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  always_comb begin
    count_d = count_q;
    if (clear_i)       count_d = '0;
    else if (enable_i) count_d = count_q + W'(1);
  end

  // Fires on the stalled cycle that brings the count up to STALL_MAX.
  assign expired_o = enable_i && !clear_i && (count_q == W'(STALL_MAX - 1));

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle main control FSM for the RV32I core: sequences fetch, decode,
// execute, memory and write-back, and drives every datapath strobe and select.
module unidad_control_multiciclo
  import control_pkg::*;
#(
  parameter int STALL_MAX = 15
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [6:0] opcode,
  input  logic       cond_ok,
  input  logic       mem_ready,
  output logic [3:0] ALUOp,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       result_src,
  output logic       error
);

  estado_t    state_q, state_d;
  logic [6:0] op_q, op_d;
  logic       in_mem;
  logic       timeout;

  assign in_mem = is_mem_state(state_q);

  contador_espera #(.STALL_MAX(STALL_MAX)) u_contador (
    .clk_i     (CLK),
    .rst_n_i   (RESET_N),
    .clear_i   (!in_mem || mem_ready),
    .enable_i  (in_mem && !mem_ready),
    .expired_o (timeout)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= RST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ALUOp      = 4'b0000;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = IORD_PC;
    reg_write  = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    result_src = RES_ALUOUT;
    error      = 1'b0;

    case (state_q)
      RST: state_d = FETCH;

      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (timeout) begin
          state_d = ERROR;
        end
      end

      DECODE: begin
        op_d      = opcode;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_R:                state_d = EXEC_R;
          OP_I:                state_d = EXEC_I;
          OP_LOAD, OP_STORE:   state_d = EXEC_LS;
          OP_BRANCH:           state_d = EXEC_B;
          OP_LUI, OP_AUIPC:    state_d = EXEC_U;
          default:             state_d = ERROR;
        endcase
      end

      EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        ALUOp     = ALUOP_R;
        state_d   = WB_ALU;
      end

      EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        ALUOp     = ALUOP_I;
        state_d   = WB_ALU;
      end

      EXEC_LS: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        if (op_q == OP_STORE) begin
          ALUOp   = ALUOP_STORE;
          state_d = MEM_SW;
        end else begin
          ALUOp   = ALUOP_LOAD;
          state_d = MEM_LW;
        end
      end

      EXEC_B: begin
        alu_src_a = SRC_A_RS1;
        ALUOp     = ALUOP_BRANCH;
        pc_src    = PC_SRC_ALUOUT;
        pc_write  = cond_ok;
        state_d   = FETCH;
      end

      EXEC_U: begin
        alu_src_b = SRC_B_IMM;
        if (op_q == OP_LUI) begin
          alu_src_a = SRC_A_ZERO;
          ALUOp     = ALUOP_LUI;
        end else begin
          alu_src_a = SRC_A_PC;
          ALUOp     = ALUOP_AUIPC;
        end
        state_d = WB_ALU;
      end

      MEM_LW: begin
        mem_read = 1'b1;
        iord     = IORD_ALUOUT;
        if (mem_ready)    state_d = WB_MEM;
        else if (timeout) state_d = ERROR;
      end

      MEM_SW: begin
        mem_write = 1'b1;
        iord      = IORD_ALUOUT;
        if (mem_ready)    state_d = FETCH;
        else if (timeout) state_d = ERROR;
      end

      WB_ALU: begin
        reg_write  = 1'b1;
        result_src = RES_ALUOUT;
        state_d    = FETCH;
      end

      WB_MEM: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
        state_d    = FETCH;
      end

      ERROR: error = 1'b1;

      default: state_d = ERROR;
    endcase
  end

endmodule
